// File: rtl/sseg_display_mux.sv
// -----------------------------------------------------------------------------
// sseg_display_mux
//   Time-multiplexed driver for the 2-digit common-anode 7-segment score
//   display. Each digit gets one slot of DIV clocks. A slot starts with DEAD
//   clocks with both anodes off, which stops the previous digit's segments
//   ghosting onto the next one. The two BCD inputs are copied into shadow
//   registers once per slot pair, at entry to GAP_LO. An input change
//   therefore never tears a pair in half.
//
//   Optional feature macro: SSEG_BLINK_EN
//     When defined, a change of the captured score makes the display blink.
//     During the SHOW states of every odd slot pair, both anodes are held off
//     for BLINK slot pairs.
//
// Ports
//   clk_100MHz  in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-high
//   bcd_hi      in   4  tens digit, BCD
//   bcd_low     in   4  ones digit, BCD
//   seg_n       out  7  segments {g,f,e,d,c,b,a}, active-low, registered
//   an_n        out  2  anodes {hi,low}, active-low, registered
//   digit_sel   out  1  slot in progress: 0 = low digit, 1 = high digit
//
// Parameters
//   SIMULATE=1 selects DIV=8, DEAD=2 and BLINK=4 for fast simulation.
//   DEAD_CYCLES must be at least 1 and below DIV.
// -----------------------------------------------------------------------------
module sseg_display_mux #(
  parameter int SIMULATE    = 1,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int DEAD_CYCLES = 200,
  parameter int LZ_BLANK    = 1,
  parameter int BLINK_SLOTS = 500
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] bcd_hi,
  input  logic [3:0] bcd_low,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       digit_sel
);

  localparam int DIV   = (SIMULATE != 0) ? 8 : (CLK_FREQ_HZ / REFRESH_HZ);
  localparam int DEAD  = (SIMULATE != 0) ? 2 : DEAD_CYCLES;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP_END = CNT_W'(DEAD - 1);

  typedef enum logic [1:0] {
    GAP_LO  = 2'd0,
    SHOW_LO = 2'd1,
    GAP_HI  = 2'd2,
    SHOW_HI = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] slot_cnt;
  logic [3:0]       shadow_hi_p0, shadow_lo_p0;
  logic             slot_wrap;
  logic             capture;
  logic             blink_off;
  logic [6:0]       seg_nxt;
  logic [1:0]       an_nxt;

  // Active-low 7-segment decode, {g,f,e,d,c,b,a}; non-BCD codes are blank.
  function automatic logic [6:0] decode_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign slot_wrap = (slot_cnt == CNT_LAST);
  // The last clock of SHOW_HI is the edge that enters GAP_LO.
  assign capture   = (state == SHOW_HI) && slot_wrap;

  // ---- stage p0: slot counter, digit slot and FSM state ----
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      digit_sel <= 1'b0;
      state     <= GAP_LO;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + CNT_W'(1);
      if (slot_wrap) begin
        digit_sel <= ~digit_sel;
      end
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GAP_LO:  if (slot_cnt == CNT_GAP_END) state_nxt = SHOW_LO;
      SHOW_LO: if (slot_wrap)               state_nxt = GAP_HI;
      GAP_HI:  if (slot_cnt == CNT_GAP_END) state_nxt = SHOW_HI;
      SHOW_HI: if (slot_wrap)               state_nxt = GAP_LO;
      default:                              state_nxt = GAP_LO;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      shadow_hi_p0 <= 4'd0;
      shadow_lo_p0 <= 4'd0;
    end else if (capture) begin
      shadow_hi_p0 <= bcd_hi;
      shadow_lo_p0 <= bcd_low;
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int BLINK = (SIMULATE != 0) ? 4 : BLINK_SLOTS;
  localparam int BLK_W = $clog2(BLINK + 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             pair_odd;

  // Pair parity and the blink budget both advance at the GAP_LO capture.
  // The new pair therefore sees consistent values from its first SHOW clock.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      pair_odd  <= 1'b0;
    end else if (capture) begin
      pair_odd <= ~pair_odd;
      if ({bcd_hi, bcd_low} != {shadow_hi_p0, shadow_lo_p0}) begin
        blink_cnt <= BLK_W'(BLINK);
      end else if (blink_cnt != '0) begin
        blink_cnt <= blink_cnt - BLK_W'(1);
      end
    end
  end

  assign blink_off = (blink_cnt != '0) && pair_odd;
`else
  assign blink_off = 1'b0;
`endif

  // Anodes stay off in the gaps. They also stay off while a digit is blanked,
  // either by leading-zero suppression or by blinking; the segment bus is
  // then idled as well.
  always_comb begin
    an_nxt  = 2'b11;
    seg_nxt = 7'h7F;
    case (state)
      SHOW_LO: begin
        if (!blink_off) begin
          an_nxt  = 2'b10;
          seg_nxt = decode_seg(shadow_lo_p0);
        end
      end
      SHOW_HI: begin
        if (!blink_off && !((LZ_BLANK != 0) && (shadow_hi_p0 == 4'd0))) begin
          an_nxt  = 2'b01;
          seg_nxt = decode_seg(shadow_hi_p0);
        end
      end
      default: ;
    endcase
  end

  // ---- stage p1: registered display outputs ----
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      seg_n <= 7'h7F;
      an_n  <= 2'b11;
    end else begin
      seg_n <= seg_nxt;
      an_n  <= an_nxt;
    end
  end

endmodule
